fir_sample_loader: RTL
======================

FIR_SAMPLE_LOADER -- requirements
Module: fir_sample_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10, sample-memory address width (1024 locations).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port arm, input, 1, one-cycle request to begin a load job.
REQ-006 SHALL have port cfg_base_addr, input, ADDR_W, first memory address of the job; sampled on an accepted arm.
REQ-007 SHALL have port cfg_count, input, ADDR_W, number of samples in the job; sampled on an accepted arm.
REQ-008 SHALL have port abort, input, 1, cancels a job in LOAD.
REQ-009 SHALL have port s_valid, input, 1, upstream sample valid.
REQ-010 SHALL have port s_data, input, DATA_W, upstream sample (two's complement).
REQ-011 SHALL have port s_ready, output, 1, loader accepts a sample when s_valid and s_ready are both high.
REQ-012 SHALL have port mem_we, output, 1, write enable to FIR sample memory port A.
REQ-013 SHALL have port mem_addr, output, ADDR_W, write address.
REQ-014 SHALL have port mem_wdata, output, DATA_W, write data.
REQ-015 SHALL have port fir_start, output, 1, one-cycle start pulse to FIR top.
REQ-016 SHALL have port fir_done, input, 1, completion level from FIR top.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port loaded_count, output, ADDR_W, samples accepted in the current or most recent job.
REQ-019 SHALL have port cfg_err, output, 1, sticky flag for an arm with cfg_count = 0.

Function
REQ-020 SHALL implement FSM states IDLE, LOAD, KICK, WAIT_FIR.
REQ-021 IDLE: arm with cfg_count != 0 SHALL latch base and count, clear loaded_count and cfg_err, and go to LOAD.
REQ-022 IDLE: arm with cfg_count = 0 SHALL set cfg_err, stay in IDLE, and produce no write or fir_start.
REQ-023 arm outside IDLE SHALL be ignored.
REQ-024 s_ready SHALL be registered: high in LOAD only, and low in the cycle after the final beat is accepted.
REQ-025 A beat k accepted in cycle T SHALL produce mem_we=1, mem_addr=(base+k) mod 2^ADDR_W, and mem_wdata=s_data in cycle T+1.
REQ-026 mem_we SHALL be 0 in every other cycle.
REQ-027 Address SHALL wrap from 2^ADDR_W-1 to 0 without error.
REQ-028 loaded_count SHALL increment by 1 in the cycle after each acceptance.
REQ-029 A gap in s_valid SHALL stall the job with no write and no timeout.
REQ-030 Final beat accepted in cycle T_L: SHALL enter KICK at T_L+1, assert fir_start=1 for exactly cycle T_L+2, and enter WAIT_FIR at T_L+3.
REQ-031 WAIT_FIR SHALL return to IDLE in the cycle after fir_done is sampled high; fir_done in any other state SHALL be ignored.
REQ-032 abort in LOAD SHALL return to IDLE next cycle; a write for a beat accepted in the abort cycle SHALL still issue; no fir_start SHALL issue; loaded_count SHALL be retained.
REQ-033 abort outside LOAD SHALL be ignored.
REQ-034 If abort and the final acceptance occur in the same cycle, abort SHALL win.

Reset
REQ-035 With rst=0 at a clock edge, the block SHALL enter IDLE and drive s_ready, mem_we, mem_addr, mem_wdata, fir_start, busy, loaded_count and cfg_err to 0.
REQ-036 Reset SHALL drop any pending write.
REQ-037 Reset SHALL have priority over arm, abort, fir_done and stream activity.

Verification
REQ-038 Basic job: base=0, count=4, data 10,20,-30,40 with continuous valid -> writes to addr 0..3 in consecutive cycles; fir_start one cycle, two cycles after the last acceptance; busy low one cycle after fir_done.
REQ-039 Wrap: base=1022, count=4 -> writes to addr 1022, 1023, 0, 1; loaded_count=4.
REQ-040 Stalls: count=3 with s_valid low for 2 cycles between beats -> exactly 3 writes; no write during the gaps.
REQ-041 Zero count: arm with count=0 -> cfg_err=1, busy=0, no mem_we and no fir_start; a subsequent valid arm clears cfg_err.
REQ-042 Abort: count=8, abort asserted with the 3rd acceptance -> 3 writes, no fir_start, loaded_count=3, IDLE next cycle.
REQ-043 Mid-job reset: rst=0 after 2 of 5 beats -> all outputs 0 next cycle; the following arm with base=512, count=2 runs normally.

Source files
------------

// File: rtl/fir_sample_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_sample_loader                                             |
// | Purpose  : Streams a job of samples into FIR sample memory, then kicks   |
// |            the FIR and waits for its completion level.                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fir_sample_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_count,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              fir_start,
  input  logic              fir_done,
  output logic              busy,
  output logic [ADDR_W-1:0] loaded_count,
  output logic              cfg_err
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_LOAD     = 2'd1;
  localparam logic [1:0] c_KICK     = 2'd2;
  localparam logic [1:0] c_WAIT_FIR = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_loaded;
  logic              r_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_start;
  logic              r_err;

  logic              w_accept;
  logic              w_last;
  logic [ADDR_W-1:0] w_loaded_inc;
  logic [ADDR_W-1:0] w_wr_addr;

  // r_ready is only ever high in LOAD, so it doubles as the LOAD qualifier.
  assign w_accept     = r_ready & s_valid;
  assign w_loaded_inc = r_loaded + 1'b1;
  assign w_last       = w_accept && (w_loaded_inc == r_count);
  assign w_wr_addr    = r_base + r_loaded;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= c_IDLE;
      r_base   <= '0;
      r_count  <= '0;
      r_loaded <= '0;
      r_ready  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_start  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_we    <= w_accept;
      r_start <= 1'b0;
      if (w_accept) begin
        r_addr   <= w_wr_addr;
        r_wdata  <= s_data;
        r_loaded <= w_loaded_inc;
      end
      case (r_state)
        c_IDLE: begin
          if (arm) begin
            if (cfg_count == '0) begin
              r_err <= 1'b1;
            end else begin
              r_base   <= cfg_base_addr;
              r_count  <= cfg_count;
              r_loaded <= '0;
              r_err    <= 1'b0;
              r_ready  <= 1'b1;
              r_state  <= c_LOAD;
            end
          end
        end
        c_LOAD: begin
          // Abort outranks a simultaneous final beat; the beat's write still lands.
          if (abort) begin
            r_ready <= 1'b0;
            r_state <= c_IDLE;
          end else if (w_last) begin
            r_ready <= 1'b0;
            r_state <= c_KICK;
          end
        end
        c_KICK: begin
          // Two cycles here: the first arms the pulse, the second carries it.
          if (!r_start) begin
            r_start <= 1'b1;
          end else begin
            r_state <= c_WAIT_FIR;
          end
        end
        c_WAIT_FIR: begin
          if (fir_done) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign s_ready      = r_ready;
  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign fir_start    = r_start;
  assign busy         = (r_state != c_IDLE);
  assign loaded_count = r_loaded;
  assign cfg_err      = r_err;

endmodule
`default_nettype wire
